// File: rtl/debouncer_multi.sv
// debouncer_multi: NUM_CH independent push-button conditioners. Each channel
// has a 2-flop synchroniser, a glitch-rejecting stability counter, registered
// press/release pulses and a long-press detector with optional auto-repeat.
module debouncer_multi #(
  parameter int NUM_CH        = 3,
  parameter int DEBOUNCE_TIME = 50000,
  parameter int CNT_W         = 16,
  parameter int HOLD_TIME     = 50000000,
  parameter int REPEAT_TIME   = 0,
  parameter int HOLD_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn,
  output logic [NUM_CH-1:0] btn_stable,
  output logic [NUM_CH-1:0] btn_rise,
  output logic [NUM_CH-1:0] btn_fall,
  output logic [NUM_CH-1:0] btn_long,
  output logic [NUM_CH-1:0] btn_repeat
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } hold_state_t;

  // Terminal counts, pre-sized so every compare is a plain equality.
  localparam logic [CNT_W-1:0]  DB_CMP   = CNT_W'(DEBOUNCE_TIME - 1);
  localparam logic [HOLD_W-1:0] HOLD_CMP = HOLD_W'(HOLD_TIME);
  localparam logic [HOLD_W-1:0] REP_CMP  = HOLD_W'((REPEAT_TIME > 0) ? REPEAT_TIME - 1 : 0);
  localparam bit                REP_EN   = (REPEAT_TIME > 0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_ch
      logic              s1_reg, s2_reg;
      logic              stable_reg, stable_next;
      logic              rise_reg, rise_next;
      logic              fall_reg, fall_next;
      logic              long_reg, long_next;
      logic              rep_reg, rep_next;
      logic [CNT_W-1:0]  dcnt_reg, dcnt_next;
      logic [HOLD_W-1:0] hcnt_reg, hcnt_next;
      hold_state_t       state_reg, state_next;

      // Debounce: any cycle of agreement restarts the count; a new level is
      // accepted only after DEBOUNCE_TIME consecutive mismatching cycles.
      always_comb begin
        stable_next = stable_reg;
        dcnt_next   = dcnt_reg;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        if (s2_reg == stable_reg) begin
          dcnt_next = '0;
        end else if (dcnt_reg == DB_CMP) begin
          stable_next = s2_reg;
          dcnt_next   = '0;
          rise_next   = s2_reg;
          fall_next   = ~s2_reg;
        end else begin
          dcnt_next = dcnt_reg + CNT_W'(1);
        end
      end

      // Hold FSM: a release always wins over a long/repeat firing on the same edge.
      always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        long_next  = 1'b0;
        rep_next   = 1'b0;
        if (fall_next) begin
          state_next = ST_IDLE;
          hcnt_next  = '0;
        end else begin
          unique case (state_reg)
            ST_IDLE: begin
              hcnt_next = '0;
              if (rise_next) begin
                state_next = ST_HELD;
                hcnt_next  = HOLD_W'(1);
              end
            end
            ST_HELD: begin
              if (hcnt_reg == HOLD_CMP) begin
                long_next  = 1'b1;
                hcnt_next  = '0;
                state_next = ST_LONG;
              end else begin
                hcnt_next = hcnt_reg + HOLD_W'(1);
              end
            end
            ST_LONG: begin
              if (!REP_EN) begin
                hcnt_next = '0;
              end else if (hcnt_reg == REP_CMP) begin
                rep_next  = 1'b1;
                hcnt_next = '0;
              end else begin
                hcnt_next = hcnt_reg + HOLD_W'(1);
              end
            end
            default: begin
              state_next = ST_IDLE;
              hcnt_next  = '0;
            end
          endcase
        end
      end

      // State and output registers; reset clears everything with no pulses.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s1_reg     <= 1'b0;
          s2_reg     <= 1'b0;
          stable_reg <= 1'b0;
          dcnt_reg   <= '0;
          rise_reg   <= 1'b0;
          fall_reg   <= 1'b0;
          long_reg   <= 1'b0;
          rep_reg    <= 1'b0;
          hcnt_reg   <= '0;
          state_reg  <= ST_IDLE;
        end else begin
          s1_reg     <= btn[gi];
          s2_reg     <= s1_reg;
          stable_reg <= stable_next;
          dcnt_reg   <= dcnt_next;
          rise_reg   <= rise_next;
          fall_reg   <= fall_next;
          long_reg   <= long_next;
          rep_reg    <= rep_next;
          hcnt_reg   <= hcnt_next;
          state_reg  <= state_next;
        end
      end

      assign btn_stable[gi] = stable_reg;
      assign btn_rise[gi]   = rise_reg;
      assign btn_fall[gi]   = fall_reg;
      assign btn_long[gi]   = long_reg;
      assign btn_repeat[gi] = rep_reg;
    end
  endgenerate

endmodule
